// File: rtl/student_gates_pkg.sv
// Shared definitions for the student gate library.
// Holds the coverage bitmap width, the {a,b} index encoding and the default
// occurrence-counter width used by the gate primitives.
package student_gates_pkg;

    // Coverage bitmap width: one bit per two-input combination.
    localparam int unsigned COV_W = 4;

    // Bit position in the coverage bitmap for each {a,b} combination.
    localparam logic [1:0] IDX_00 = 2'd0;
    localparam logic [1:0] IDX_01 = 2'd1;
    localparam logic [1:0] IDX_10 = 2'd2;
    localparam logic [1:0] IDX_11 = 2'd3;

    // Default width of the out-high occurrence counter.
    localparam int unsigned CNT_W_DEF = 8;

    // One-hot mask selecting the coverage bit for an {a,b} combination.
    // Unknown inputs select nothing, so X/Z never marks a combination as seen.
    function automatic logic [COV_W-1:0] cov_onehot(input logic [1:0] idx);
        logic [COV_W-1:0] mask;
        mask = '0;
        case (idx)
            IDX_00:  mask[IDX_00] = 1'b1;
            IDX_01:  mask[IDX_01] = 1'b1;
            IDX_10:  mask[IDX_10] = 1'b1;
            IDX_11:  mask[IDX_11] = 1'b1;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/student_and_cov.sv
// Truth-table coverage for a two-input gate.
// Keeps a sticky bitmap of the {a,b} combinations sampled on rising clock
// edges and a saturating count of edges sampled with the AND output high.
// A synchronous clear zeroes both and takes priority over recording.
module student_and_cov
    import student_gates_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clr_i,
    output logic [COV_W-1:0] cov_o,
    output logic             cov_full_o,
    output logic [CNT_W-1:0] hi_cnt_o
);

    logic [COV_W-1:0] cov_q, cov_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    // Counter increment that holds at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hit = a_i & b_i;

    // Next state: clear wins; otherwise mark the combination and count highs.
    always_comb begin
        cov_d = cov_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cov_d = '0;
            cnt_d = '0;
        end else begin
            cov_d = cov_q | cov_onehot({a_i, b_i});
            if (hit == 1'b1) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    // Coverage state, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cov_q <= '0;
            cnt_q <= '0;
        end else begin
            cov_q <= cov_d;
            cnt_q <= cnt_d;
        end
    end

    assign cov_o      = cov_q;
    assign cov_full_o = &cov_q;
    assign hi_cnt_o   = cnt_q;

endmodule

// File: rtl/student_and_gate.sv
// Two-input AND leaf gate with a registered copy of the result.
// Optional truth-table coverage (bitmap + saturating out-high counter) is
// built only when the macro STUDENT_AND_COVER_EN is defined; otherwise the
// coverage outputs are tied to zero and cov_clr is ignored.
module student_and_gate
    import student_gates_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             out,
    output logic             out_q,
    input  logic             cov_clr,
    output logic [COV_W-1:0] cov,
    output logic             cov_full,
    output logic [CNT_W-1:0] hi_cnt
);

    // Purely combinational result, independent of clock and reset.
    assign out = a & b;

    // Registered copy of the gate output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out;
        end
    end

`ifdef STUDENT_AND_COVER_EN
    student_and_cov #(
        .CNT_W (CNT_W)
    ) u_cov (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_i        (a),
        .b_i        (b),
        .clr_i      (cov_clr),
        .cov_o      (cov),
        .cov_full_o (cov_full),
        .hi_cnt_o   (hi_cnt)
    );
`else
    logic unused_cov_clr;
    assign unused_cov_clr = cov_clr;
    assign cov            = '0;
    assign cov_full       = 1'b0;
    assign hi_cnt         = '0;
`endif

endmodule

// File: tb/tb_student_and_gate.sv
// Bench for student_and_gate: truth-table vectors, directed reset/coverage
// sequences and randomized cycles against a behavioural reference model.
// Two instances share stimulus: default counter width and CNT_W = 2.
module tb_student_and_gate;
    import student_gates_pkg::*;

`ifdef STUDENT_AND_COVER_EN
    localparam bit COV_EN = 1'b1;
`else
    localparam bit COV_EN = 1'b0;
`endif

    localparam int unsigned W8 = CNT_W_DEF;
    localparam int unsigned W2 = 2;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;
    logic a, b, cov_clr;

    logic             out8, out_q8, cov_full8;
    logic [COV_W-1:0] cov8;
    logic [W8-1:0]    hi8;
    logic             out2, out_q2, cov_full2;
    logic [COV_W-1:0] cov2;
    logic [W2-1:0]    hi2;

    student_and_gate #(.CNT_W(W8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out8), .out_q(out_q8),
        .cov_clr(cov_clr), .cov(cov8), .cov_full(cov_full8), .hi_cnt(hi8)
    );

    student_and_gate #(.CNT_W(W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out2), .out_q(out_q2),
        .cov_clr(cov_clr), .cov(cov2), .cov_full(cov_full2), .hi_cnt(hi2)
    );

    always #5 if (clk_en) clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          seen[4];
    int unsigned cnt8_m, cnt2_m;
    bit          oq_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        cnt8_m = 0;
        cnt2_m = 0;
        oq_m   = 1'b0;
    endtask

    function automatic int unsigned exp_cov();
        int unsigned v = 0;
        for (int i = 0; i < 4; i++) if (seen[i]) v += (1 << i);
        return COV_EN ? v : 0;
    endfunction

    function automatic int unsigned exp_cnt(input int unsigned c);
        return COV_EN ? c : 0;
    endfunction

    task automatic model_edge(input bit ai, input bit bi, input bit clr);
        oq_m = ai && bi;
        if (clr) begin
            for (int i = 0; i < 4; i++) seen[i] = 1'b0;
            cnt8_m = 0;
            cnt2_m = 0;
        end else begin
            seen[ai * 2 + bi] = 1'b1;
            if (ai && bi) begin
                if (cnt8_m < (1 << W8) - 1) cnt8_m++;
                if (cnt2_m < (1 << W2) - 1) cnt2_m++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_out_q"},    32'(out_q8),    32'(oq_m));
        check({tag, "_out_q2"},   32'(out_q2),    32'(oq_m));
        check({tag, "_cov"},      32'(cov8),      exp_cov());
        check({tag, "_cov2"},     32'(cov2),      exp_cov());
        check({tag, "_full"},     32'(cov_full8), 32'(exp_cov() == 15));
        check({tag, "_full2"},    32'(cov_full2), 32'(exp_cov() == 15));
        check({tag, "_hi_cnt"},   32'(hi8),       exp_cnt(cnt8_m));
        check({tag, "_hi_cnt2"},  32'(hi2),       exp_cnt(cnt2_m));
    endtask

    // Drive one cycle of stimulus, check the combinational output, clock, check state.
    task automatic apply(input string tag, input bit ai, input bit bi, input bit clr);
        a = ai; b = bi; cov_clr = clr;
        #1;
        check({tag, "_out"},  32'(out8), 32'(ai && bi));
        check({tag, "_out2"}, 32'(out2), 32'(ai && bi));
        @(posedge clk);
        model_edge(ai, bi, clr);
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        bit a;
        bit b;
        bit out;
    } tt_vec_t;

    tt_vec_t     tt[4];
    int unsigned sat_exp[6];

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tt[0] = '{1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b1, 1'b0, 1'b0};
        tt[3] = '{1'b1, 1'b1, 1'b1};
        sat_exp = '{1, 2, 3, 3, 3, 3};

        rst_n = 1'b0; cov_clr = 1'b0; a = 1'b0; b = 1'b0;
        model_reset();

        // Truth table with no clock activity
        for (int i = 0; i < 4; i++) begin
            a = tt[i].a; b = tt[i].b;
            #1;
            check($sformatf("tt_out_%0d%0d", tt[i].a, tt[i].b), 32'(out8), 32'(tt[i].out));
        end

        // Reset behaviour with a=b=1 held
        a = 1'b1; b = 1'b1;
        #1;
        check("rst_out",    32'(out8),      32'd1);
        check("rst_out_q",  32'(out_q8),    32'd0);
        check("rst_cov",    32'(cov8),      32'd0);
        check("rst_full",   32'(cov_full8), 32'd0);
        check("rst_hi_cnt", 32'(hi8),       32'd0);
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        apply("first", 1'b1, 1'b1, 1'b0);
        check("first_out_q_k",  32'(out_q8), 32'd1);
        check("first_hi_cnt_k", 32'(hi8),    COV_EN ? 32'd1 : 32'd0);
        check("first_cov_k",    32'(cov8),   COV_EN ? 32'h8 : 32'd0);

        // Full coverage after a clear
        apply("pre_clr", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply($sformatf("fc%0d", i), tt[i].a, tt[i].b, 1'b0);
        check("fc_cov_k",  32'(cov8),      COV_EN ? 32'hF : 32'd0);
        check("fc_full_k", 32'(cov_full8), COV_EN ? 32'd1 : 32'd0);
        check("fc_hi_k",   32'(hi8),       COV_EN ? 32'd1 : 32'd0);

        // Clear priority over recording
        apply("clrp", 1'b1, 1'b1, 1'b1);
        check("clrp_cov_k", 32'(cov8), 32'd0);
        check("clrp_hi_k",  32'(hi8),  32'd0);
        apply("clrp_next", 1'b1, 1'b1, 1'b0);
        check("clrp_next_cov_k", 32'(cov8), COV_EN ? 32'h8 : 32'd0);

        // Saturation on the 2-bit counter
        apply("sat_clr", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0);
            check($sformatf("sat_hi2_k%0d", i), 32'(hi2), COV_EN ? sat_exp[i] : 32'd0);
        end

        // Asynchronous reset pulse between edges
        for (int i = 0; i < 3; i++) apply($sformatf("ar%0d", i), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_out_q",  32'(out_q8), 32'd0);
        check("ar_cov",    32'(cov8),   32'd0);
        check("ar_hi_cnt", 32'(hi8),    32'd0);
        check("ar_hi_cnt2", 32'(hi2),   32'd0);
        check("ar_out",    32'(out8),   32'd1);
        #1;
        rst_n = 1'b1;

        // Randomized cycles against the model
        for (int i = 0; i < 300; i++) begin
            apply("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
